// File: rtl/sc_regserializer_pkg.sv
// -----------------------------------------------------------------------------
// sc_regserializer_pkg
// Shared definitions for the register serializer: FSM state encoding, default
// parameter values and a counter-width helper.
// -----------------------------------------------------------------------------
package sc_regserializer_pkg;

    localparam int unsigned DefaultDataWidth = 8;
    localparam int unsigned DefaultBitPeriod = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sc_regserializer_bittimer.sv
// -----------------------------------------------------------------------------
// sc_regserializer_bittimer
// Period counter that times how long each serial bit is held. While enabled it
// counts 0..BitPeriod-1 and wraps to 0; wrap is high in the last cycle of a bit
// period. Disabled, the counter is held at 0 so every frame starts aligned.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   enable  counting enable (high while the serializer is shifting)
//   wrap    strobe, high in the final cycle of each bit period
// -----------------------------------------------------------------------------
module sc_regserializer_bittimer
    import sc_regserializer_pkg::*;
#(
    parameter int unsigned BitPeriod = DefaultBitPeriod
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic wrap
);

    localparam int unsigned CntW = cnt_width(BitPeriod);
    localparam logic [CntW-1:0] LastCnt = CntW'(BitPeriod - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // With BitPeriod=1 the counter sits at 0 and wrap follows enable directly.
    assign wrap = enable && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sc_regserializer.sv
// -----------------------------------------------------------------------------
// sc_regserializer
// Parallel-to-serial converter for the general register output bus. A low
// sample of start_InLow in IDLE captures the bus word; the word is then sent
// MSB first, each bit held BITPERIOD cycles, followed by a one-cycle active-low
// done strobe. Requests while busy are dropped. All outputs come from flops.
//
// Ports:
//   SC_RegSERIALIZER_CLOCK_50      system clock, rising edge
//   SC_RegSERIALIZER_RESET_InHigh  asynchronous active-high reset
//   SC_RegSERIALIZER_start_InLow   active-low transfer request (level)
//   SC_RegSERIALIZER_data_InBUS    parallel word to send
//   SC_RegSERIALIZER_serial_Out    serial line, idles high
//   SC_RegSERIALIZER_valid_Out     high while a data bit is driven
//   SC_RegSERIALIZER_busy_Out      high from first data bit through done cycle
//   SC_RegSERIALIZER_done_OutLow   active-low one-cycle end-of-frame strobe
// -----------------------------------------------------------------------------
module sc_regserializer
    import sc_regserializer_pkg::*;
#(
    parameter int unsigned RegSERIALIZER_DATAWIDTH = DefaultDataWidth,
    parameter int unsigned RegSERIALIZER_BITPERIOD = DefaultBitPeriod
) (
    input  logic                               SC_RegSERIALIZER_CLOCK_50,
    input  logic                               SC_RegSERIALIZER_RESET_InHigh,
    input  logic                               SC_RegSERIALIZER_start_InLow,
    input  logic [RegSERIALIZER_DATAWIDTH-1:0] SC_RegSERIALIZER_data_InBUS,
    output logic                               SC_RegSERIALIZER_serial_Out,
    output logic                               SC_RegSERIALIZER_valid_Out,
    output logic                               SC_RegSERIALIZER_busy_Out,
    output logic                               SC_RegSERIALIZER_done_OutLow
);

    localparam int unsigned W       = RegSERIALIZER_DATAWIDTH;
    localparam int unsigned BitCntW = $clog2(W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(W - 1);

    logic clk;
    logic rst;
    assign clk = SC_RegSERIALIZER_CLOCK_50;
    assign rst = SC_RegSERIALIZER_RESET_InHigh;

    state_e             state_q, state_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [BitCntW-1:0] bitcnt_q, bitcnt_d;
    logic               wrap;

    logic serial_q, serial_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;
    logic done_n_q, done_n_d;

    sc_regserializer_bittimer #(
        .BitPeriod (RegSERIALIZER_BITPERIOD)
    ) u_bittimer (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == StShift),
        .wrap   (wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!SC_RegSERIALIZER_start_InLow) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (wrap && (bitcnt_q == LastBit)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Shift register and bit counter. The word is only loaded in IDLE, so bus
    // activity during a frame cannot reach the line.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        if (state_q == StIdle) begin
            bitcnt_d = '0;
            if (!SC_RegSERIALIZER_start_InLow) begin
                shreg_d = SC_RegSERIALIZER_data_InBUS;
            end
        end else if ((state_q == StShift) && wrap) begin
            shreg_d  = {shreg_q[W-2:0], 1'b0};
            bitcnt_d = bitcnt_q + BitCntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Output logic: decoded from the next state so the output flops line up
    // with the state they describe.
    always_comb begin
        serial_d = (state_d == StShift) ? shreg_d[W-1] : 1'b1;
        valid_d  = (state_d == StShift);
        busy_d   = (state_d != StIdle);
        done_n_d = (state_d != StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            serial_q <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_n_q <= 1'b1;
        end else begin
            serial_q <= serial_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_n_q <= done_n_d;
        end
    end

    assign SC_RegSERIALIZER_serial_Out  = serial_q;
    assign SC_RegSERIALIZER_valid_Out   = valid_q;
    assign SC_RegSERIALIZER_busy_Out    = busy_q;
    assign SC_RegSERIALIZER_done_OutLow = done_n_q;

endmodule

// File: tb/tb_sc_regserializer.sv
// -----------------------------------------------------------------------------
// tb_sc_regserializer
// Self-checking bench for sc_regserializer. One instance uses DATAWIDTH=8,
// BITPERIOD=4; a second uses BITPERIOD=1. Inputs change and outputs are
// sampled 1 time unit after each rising edge. Cycle c of a frame is the cycle
// following edge c-1, where edge 0 is the capture edge.
// -----------------------------------------------------------------------------
module tb_sc_regserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic [7:0] data, data1;
    logic       serial, valid, busy, done_n;
    logic       serial1, valid1, busy1, done_n1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_regserializer #(
        .RegSERIALIZER_DATAWIDTH (8),
        .RegSERIALIZER_BITPERIOD (4)
    ) dut (
        .SC_RegSERIALIZER_CLOCK_50     (clk),
        .SC_RegSERIALIZER_RESET_InHigh (rst),
        .SC_RegSERIALIZER_start_InLow  (start),
        .SC_RegSERIALIZER_data_InBUS   (data),
        .SC_RegSERIALIZER_serial_Out   (serial),
        .SC_RegSERIALIZER_valid_Out    (valid),
        .SC_RegSERIALIZER_busy_Out     (busy),
        .SC_RegSERIALIZER_done_OutLow  (done_n)
    );

    sc_regserializer #(
        .RegSERIALIZER_DATAWIDTH (8),
        .RegSERIALIZER_BITPERIOD (1)
    ) dut1 (
        .SC_RegSERIALIZER_CLOCK_50     (clk),
        .SC_RegSERIALIZER_RESET_InHigh (rst),
        .SC_RegSERIALIZER_start_InLow  (start1),
        .SC_RegSERIALIZER_data_InBUS   (data1),
        .SC_RegSERIALIZER_serial_Out   (serial1),
        .SC_RegSERIALIZER_valid_Out    (valid1),
        .SC_RegSERIALIZER_busy_Out     (busy1),
        .SC_RegSERIALIZER_done_OutLow  (done_n1)
    );

    typedef struct {
        logic [7:0] data;      // word placed on the bus at capture
        logic [7:0] exp_bits;  // expected line bits, index 7 sent first
        int         pulse_at;  // frame cycle with an extra start pulse, 0 = none
    } frame_t;

    frame_t vec[7];

    task automatic chk(input string name, input int cyc, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int cyc, input logic s, input logic v,
                              input logic b, input logic d);
        chk({tag, ".serial"}, cyc, serial, s);
        chk({tag, ".valid"},  cyc, valid,  v);
        chk({tag, ".busy"},   cyc, busy,   b);
        chk({tag, ".done_n"}, cyc, done_n, d);
    endtask

    task automatic check_outs1(input string tag, input int cyc, input logic s, input logic v,
                               input logic b, input logic d);
        chk({tag, ".serial"}, cyc, serial1, s);
        chk({tag, ".valid"},  cyc, valid1,  v);
        chk({tag, ".busy"},   cyc, busy1,   b);
        chk({tag, ".done_n"}, cyc, done_n1, d);
    endtask

    // Starts from an idle cycle; the bus is inverted right after capture.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [7:0] bits,
                             input int pulse_at);
        start = 1'b0;
        data  = d;
        tick;
        start = 1'b1;
        data  = ~d;
        for (int c = 1; c <= 32; c++) begin
            check_outs({tag, ".shift"}, c, bits[7 - (c - 1) / 4], 1'b1, 1'b1, 1'b1);
            start = (c == pulse_at) ? 1'b0 : 1'b1;
            tick;
        end
        start = 1'b1;
        check_outs({tag, ".done"}, 33, 1'b1, 1'b0, 1'b1, 1'b0);
        tick;
        check_outs({tag, ".idle"}, 34, 1'b1, 1'b0, 1'b0, 1'b1);
        tick;
        check_outs({tag, ".idle2"}, 35, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle 0 actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b2b;
        int         pos;

        vec[0] = '{data: 8'hA5, exp_bits: 8'b1010_0101, pulse_at: 0};
        vec[1] = '{data: 8'h5A, exp_bits: 8'b0101_1010, pulse_at: 0};
        vec[2] = '{data: 8'h00, exp_bits: 8'b0000_0000, pulse_at: 0};
        vec[3] = '{data: 8'hFF, exp_bits: 8'b1111_1111, pulse_at: 0};
        vec[4] = '{data: 8'h01, exp_bits: 8'b0000_0001, pulse_at: 0};
        vec[5] = '{data: 8'h80, exp_bits: 8'b1000_0000, pulse_at: 0};
        vec[6] = '{data: 8'h96, exp_bits: 8'b1001_0110, pulse_at: 10};

        rst    = 1'b1;
        start  = 1'b1;
        start1 = 1'b1;
        data   = 8'h00;
        data1  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_outs1("reset1", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        tick;
        check_outs("post_reset", 0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Single frames, including one with a start pulse while busy.
        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("vec%0d", i), vec[i].data, vec[i].exp_bits, vec[i].pulse_at);
        end

        // Reset in cycle 15 of a 0xFF frame, then a clean 0x3C frame.
        start = 1'b0;
        data  = 8'hFF;
        tick;
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            check_outs("pre_rst", c, 1'b1, 1'b1, 1'b1, 1'b1);
            tick;
        end
        rst = 1'b1;
        #1;
        check_outs("mid_rst", 15, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        tick;
        check_outs("after_rst", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick;
        check_outs("after_rst2", 0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame("rst_3c", 8'h3C, 8'b0011_1100, 0);

        // Start held low: frames repeat with a 34-cycle period.
        b2b   = 8'b1000_0001;
        start = 1'b0;
        data  = 8'h81;
        tick;
        for (int c = 1; c <= 102; c++) begin
            pos = (c - 1) % 34;
            if (pos < 32) begin
                check_outs("b2b.shift", c, b2b[7 - pos / 4], 1'b1, 1'b1, 1'b1);
            end else if (pos == 32) begin
                check_outs("b2b.done", c, 1'b1, 1'b0, 1'b1, 1'b0);
            end else begin
                check_outs("b2b.idle", c, 1'b1, 1'b0, 1'b0, 1'b1);
            end
            if (c == 102) begin
                start = 1'b1;
            end
            tick;
        end
        check_outs("b2b.end", 103, 1'b1, 1'b0, 1'b0, 1'b1);

        // BITPERIOD=1: capture 0x00, then drive 0xFF during the frame.
        start1 = 1'b0;
        data1  = 8'h00;
        tick;
        start1 = 1'b1;
        data1  = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            check_outs1("p1.shift", c, 1'b0, 1'b1, 1'b1, 1'b1);
            tick;
        end
        check_outs1("p1.done", 9, 1'b1, 1'b0, 1'b1, 1'b0);
        tick;
        check_outs1("p1.idle", 10, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_regserializer.md
SC_REGSERIALIZER -- requirements
Module: sc_regserializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: SC_RegSERIALIZER_CLOCK_50 and SC_RegSERIALIZER_RESET_InHigh.
REQ-002 Parameter: RegSERIALIZER_DATAWIDTH, 8, parallel word width in bits (>=2).
REQ-003 Parameter: RegSERIALIZER_BITPERIOD, 4, clock cycles each serial bit is held (>=1).
REQ-004 SC_RegSERIALIZER_CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-005 SC_RegSERIALIZER_RESET_InHigh  input  1  asynchronous active-high reset.
REQ-006 SC_RegSERIALIZER_start_InLow  input  1  active-low transfer request, level-sampled every cycle.
REQ-007 SC_RegSERIALIZER_data_InBUS  input  DATAWIDTH  parallel word from the general register output bus.
REQ-008 SC_RegSERIALIZER_serial_Out  output  1  serial data line; idles high.
REQ-009 SC_RegSERIALIZER_valid_Out  output  1  high while a data bit is being driven.
REQ-010 SC_RegSERIALIZER_busy_Out  output  1  high from the first data bit through the done cycle.
REQ-011 SC_RegSERIALIZER_done_OutLow  output  1  active-low, one-cycle end-of-frame strobe.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: serial_Out=1, valid_Out=0, busy_Out=0, done_OutLow=1.
REQ-014 IDLE with start_InLow=0 at edge k SHALL capture data_InBUS into the shift register at edge k and enter SHIFT.
REQ-015 SHIFT SHALL drive bits MSB first; serial_Out=MSB of the captured word from cycle k+1; valid_Out=1; busy_Out=1.
REQ-016 Each bit SHALL be held for exactly BITPERIOD cycles, timed by a period counter that counts 0..BITPERIOD-1 and then wraps to 0.
REQ-017 On each period-counter wrap the shift register SHALL shift left by one, fill 0, and increment the bit counter.
REQ-018 After bit DATAWIDTH-1 completes, the FSM SHALL enter DONE.
REQ-019 Total SHIFT duration SHALL be DATAWIDTH*BITPERIOD cycles.
REQ-020 DONE SHALL last exactly one cycle (cycle k+1+DATAWIDTH*BITPERIOD): done_OutLow=0, busy_Out=1, valid_Out=0, serial_Out=1.
REQ-021 The FSM SHALL return to IDLE unconditionally after DONE.
REQ-022 start_InLow in SHIFT or DONE SHALL be ignored, not queued.
REQ-023 data_InBUS changes after capture SHALL NOT affect the frame in progress.
REQ-024 start_InLow held low continuously SHALL produce back-to-back frames with exactly one DONE cycle and one IDLE cycle between them.
REQ-025 The bit counter SHALL be $clog2(DATAWIDTH) bits wide and the period counter max(1,$clog2(BITPERIOD)) bits wide; BITPERIOD=1 SHALL shift every cycle.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, serial_Out=1, valid_Out=0, busy_Out=0, done_OutLow=1, and clear all counters and the shift register, including mid-frame.
REQ-028 After reset deassertion, the first start_InLow=0 sample SHALL begin a fresh frame; no partial frame SHALL resume.

Structure
REQ-029 A shared package sc_regserializer_pkg SHALL hold the state typedef (IDLE/SHIFT/DONE encoding) and default parameter constants.
REQ-030 Bit timing SHALL be one sub-module, sc_regserializer_bittimer, with a period counter and a wrap-strobe output; the FSM, bit counter and shift register SHALL stay in the top module.

Verification
REQ-031 Word-frame test: DATAWIDTH=8, BITPERIOD=4, data 0xA5, start low for 1 cycle -> serial_Out = 1,0,1,0,0,1,0,1 with each bit held 4 cycles; done_OutLow low only at cycle 33 after the capture edge.
REQ-032 Busy-ignore test: start pulsed again at cycle 10 of a frame -> no change to the frame; exactly one done strobe; IDLE afterwards.
REQ-033 Mid-frame reset test: reset asserted at cycle 15 of a 0xFF frame -> outputs are at reset values in the same cycle; a new 0x3C start afterwards yields a clean 0x3C frame.
REQ-034 Back-to-back test: start held low with data 0x81 -> frames repeat every 34 cycles (32 shift cycles, 1 DONE, 1 IDLE).
REQ-035 Data-change and period-1 test: BITPERIOD=1, capture 0x00, then change data_InBUS to 0xFF during SHIFT -> serial_Out is low for exactly 8 cycles; done at cycle 9.
